// File: rtl/r_if_stage.sv
// r_if_stage: fetch/decode/issue FSM feeding R-type instructions from a synchronous instruction memory.
module r_if_stage #(
    parameter int PC_W     = 6,
    parameter int START_PC = 0
) (
    input  logic            clka,
    input  logic            rsta,
    output logic [PC_W-1:0] im_addr,
    input  logic [31:0]     im_data,
    input  logic            ex_ready,
    output logic            valid,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [2:0]      alu_op,
    output logic [PC_W-1:0] pc_out,
    output logic            halt
);
    typedef enum logic [1:0] {FETCH, DECODE, ISSUE, HALT} state_t;
    state_t state, state_n;
    logic [PC_W-1:0] pc;
    logic [2:0] op;
    logic legal, nop, rtype, unused;
    assign unused = ^im_data[10:6];
    assign im_addr = pc;
    assign valid = state == ISSUE;
    assign halt = state == HALT;
    assign nop = im_data == 32'h0;
    assign rtype = im_data[31:26] == 6'h00 && legal && !nop;
    always_comb begin
        legal = 1'b1;
        op = 3'b000;
        case (im_data[5:0])
            6'h24: op = 3'b000;
            6'h25: op = 3'b001;
            6'h20: op = 3'b010;
            6'h26: op = 3'b011;
            6'h27: op = 3'b100;
            6'h2B: op = 3'b101;
            6'h22: op = 3'b110;
            6'h2A: op = 3'b111;
            default: legal = 1'b0;
        endcase
    end
    always_comb begin
        state_n = state;
        case (state)
            FETCH:  state_n = DECODE;
            DECODE: state_n = nop ? FETCH : rtype ? ISSUE : HALT;
            ISSUE:  state_n = ex_ready ? FETCH : ISSUE;
            HALT:   state_n = HALT;
            default: state_n = FETCH;
        endcase
    end
    // pc only advances on a retired NOP or an accepted issue; illegal words leave it on the offender
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state  <= FETCH;
            pc     <= PC_W'(START_PC);
            rs     <= '0;
            rt     <= '0;
            rd     <= '0;
            alu_op <= '0;
            pc_out <= '0;
        end else begin
            state <= state_n;
            if ((state == DECODE && nop) || (state == ISSUE && ex_ready))
                pc <= pc + 1'b1;
            if (state == DECODE && rtype) begin
                rs     <= im_data[25:21];
                rt     <= im_data[20:16];
                rd     <= im_data[15:11];
                alu_op <= op;
                pc_out <= pc;
            end
        end
    end
endmodule

// File: tb/tb_r_if_stage.sv
// tb_r_if_stage: directed scoreboard bench for r_if_stage, with a narrow-PC second instance for wrap checks.
module tb_r_if_stage;
    typedef struct {
        logic [4:0] rs, rt, rd;
        logic [2:0] op;
        logic [5:0] pc;
    } exp_t;

    logic clka = 0, rsta = 1, rst2 = 1, ex_ready = 1;
    logic [5:0] im_addr, pc_out;
    logic [31:0] im_data, im_data2;
    logic valid, halt, valid2, halt2;
    logic [4:0] rs, rt, rd, rs2, rt2, rd2;
    logic [2:0] alu_op, alu_op2;
    logic [1:0] im_addr2, pc_out2;
    logic [31:0] mem [64];
    logic [31:0] mem2 [4];
    exp_t q[$];
    int vectors = 0, errors = 0;

    always #5 clka = ~clka;
    always @(posedge clka) im_data <= mem[im_addr];
    always @(posedge clka) im_data2 <= mem2[im_addr2];

    r_if_stage #(.PC_W(6), .START_PC(0)) dut (
        .clka(clka), .rsta(rsta), .im_addr(im_addr), .im_data(im_data), .ex_ready(ex_ready),
        .valid(valid), .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .pc_out(pc_out), .halt(halt)
    );
    r_if_stage #(.PC_W(2), .START_PC(0)) dut2 (
        .clka(clka), .rsta(rst2), .im_addr(im_addr2), .im_data(im_data2), .ex_ready(ex_ready),
        .valid(valid2), .rs(rs2), .rt(rt2), .rd(rd2), .alu_op(alu_op2), .pc_out(pc_out2), .halt(halt2)
    );

    function automatic logic [31:0] rinst(input logic [4:0] s, t, d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] s, t, d, input logic [2:0] o, input logic [5:0] p);
        exp_t e;
        e.rs = s; e.rt = t; e.rd = d; e.op = o; e.pc = p;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input bit which, input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, 1, 0);
            return;
        end
        e = q.pop_front();
        chk({tag, "_rs"}, which ? rs2 : rs, e.rs);
        chk({tag, "_rt"}, which ? rt2 : rt, e.rt);
        chk({tag, "_rd"}, which ? rd2 : rd, e.rd);
        chk({tag, "_op"}, which ? alu_op2 : alu_op, e.op);
        chk({tag, "_pc"}, which ? {4'h0, pc_out2} : pc_out, e.pc);
    endtask

    task automatic wait_valid(input bit which, input string tag, output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clka);
            #1;
            n++;
            if (which ? valid2 : valid) return;
        end
        chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic release_rst();
        @(negedge clka);
        rsta = 0;
    endtask

    task automatic hold_rst();
        rsta = 1;
        @(posedge clka);
        #1;
    endtask

    initial begin
        int n;
        foreach (mem[i]) mem[i] = 32'h0;
        // reset state
        hold_rst();
        chk("rst_valid", valid, 0);
        chk("rst_halt", halt, 0);
        chk("rst_fields", {rs, rt, rd, alu_op}, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_im_addr", im_addr, 0);

        // single add, accepted immediately
        mem[0] = 32'h00221820;
        ex_ready = 1;
        push(1, 2, 3, 3'b010, 0);
        release_rst();
        wait_valid(0, "add", n);
        chk("add_latency", n, 2);
        pop_cmp(0, "add");
        @(posedge clka);
        #1;
        chk("add_valid_drop", valid, 0);
        chk("add_next_addr", im_addr, 1);

        // sub held by back-pressure for 5 cycles
        hold_rst();
        mem[0] = 32'h00221822;
        ex_ready = 0;
        push(1, 2, 3, 3'b110, 0);
        release_rst();
        wait_valid(0, "sub", n);
        pop_cmp(0, "sub");
        for (int i = 0; i < 5; i++) begin
            @(posedge clka);
            #1;
            chk("sub_hold", {valid, rs, rt, rd, alu_op, im_addr}, {1'b1, 5'd1, 5'd2, 5'd3, 3'b110, 6'd0});
        end
        ex_ready = 1;
        @(posedge clka);
        #1;
        chk("sub_accept", {valid, im_addr}, {1'b0, 6'd1});

        // NOP skipped, then and at address 1
        hold_rst();
        mem[0] = 32'h0;
        mem[1] = 32'h00221824;
        push(1, 2, 3, 3'b000, 1);
        release_rst();
        wait_valid(0, "nop", n);
        chk("nop_latency", n, 4);
        pop_cmp(0, "nop");

        // illegal lw halts until reset
        hold_rst();
        mem[0] = 32'h8C220000;
        release_rst();
        repeat (2) @(posedge clka);
        #1;
        chk("ill_halt", {halt, valid}, 2'b10);
        for (int i = 0; i < 10; i++) begin
            @(posedge clka);
            #1;
            chk("ill_stay", {halt, valid, im_addr}, {1'b1, 1'b0, 6'd0});
        end
        #2 rsta = 1;
        #1 chk("ill_rst_halt", halt, 0);
        mem[0] = 32'h00221820;
        push(1, 2, 3, 3'b010, 0);
        release_rst();
        wait_valid(0, "ill_restart", n);
        pop_cmp(0, "ill_restart");

        // async reset mid-ISSUE discards the instruction
        hold_rst();
        mem[0] = rinst(4, 5, 6, 6'h2A);
        mem[1] = 32'h00221822;
        ex_ready = 0;
        release_rst();
        wait_valid(0, "arst", n);
        ex_ready = 1;
        #2 rsta = 1;
        #1 chk("arst_valid", valid, 0);
        @(posedge clka);
        #1;
        chk("arst_no_inc", im_addr, 0);
        push(4, 5, 6, 3'b111, 0);
        release_rst();
        wait_valid(0, "arst_reissue", n);
        pop_cmp(0, "arst_reissue");

        // narrow PC wraps 3 -> 0 with 3-cycle issue spacing
        mem2[0] = rinst(1, 2, 3, 6'h20);
        mem2[1] = rinst(4, 5, 6, 6'h22);
        mem2[2] = rinst(7, 8, 9, 6'h25);
        mem2[3] = rinst(10, 11, 12, 6'h26);
        push(1, 2, 3, 3'b010, 0);
        push(4, 5, 6, 3'b110, 1);
        push(7, 8, 9, 3'b001, 2);
        push(10, 11, 12, 3'b011, 3);
        push(1, 2, 3, 3'b010, 0);
        ex_ready = 1;
        @(negedge clka);
        rst2 = 0;
        for (int i = 0; i < 5; i++) begin
            wait_valid(1, "wrap", n);
            if (i > 0) chk("wrap_spacing", n, 3);
            pop_cmp(1, "wrap");
        end
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
